// File: rtl/ps2_host_tx_pkg.sv
// Shared types and register map for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int unsigned DATA_OFFSET    = 0;
  localparam int unsigned STATUS_OFFSET  = 4;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_ACK_OK    = 1;
  localparam int unsigned STAT_ERROR     = 2;
  localparam int unsigned STAT_OVERRUN   = 3;
  localparam int unsigned STAT_RETRY_LSB = 4;

  localparam int unsigned RETRY_W        = 2;
  localparam int unsigned MAX_RETRIES    = 2;

  // Odd parity bit for a PS/2 frame.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Shared 2-flop synchronizer for asynchronous pad inputs; resets to RESET_VAL.
module synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter on the core IO bus (DATA/STATUS registers).
// Optional macro PS2_TX_RETRY_EN: reissue a failed frame up to two more times.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h60,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned IDX_W = 4;

  localparam logic [INH_W-1:0] INH_LAST    = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRELAST = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      DATA_ADDR   = BASE_ADDRESS + 32'(DATA_OFFSET);
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDRESS + 32'(STATUS_OFFSET);

  ps2_tx_state_t    state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             clk_oe_d, data_oe_d;
`ifdef PS2_TX_RETRY_EN
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  logic clk_sync, data_sync, clk_prev;
  logic fall, write_hit, read_hit, active, timeout;
  logic [31:0] status;
  logic unused_write_bits;

  assign unused_write_bits = ^io_write_data[31:8];

  synchronizer #(.RESET_VAL(1'b1)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ps2_clk_i),
    .q     (clk_sync)
  );

  synchronizer #(.RESET_VAL(1'b1)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ps2_data_i),
    .q     (data_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= clk_sync;
  end

  assign fall      = clk_prev & ~clk_sync;
  assign write_hit = io_write_en && (io_address == DATA_ADDR);
  assign read_hit  = io_read_en && (io_address == STATUS_ADDR);
  assign active    = (state_q == REQUEST) || (state_q == SEND) ||
                     (state_q == ACK) || (state_q == WAIT_IDLE);
  assign timeout   = active && (tmo_q == TMO_LAST);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      idx_q       <= '0;
      inh_q       <= '0;
      tmo_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      idx_q       <= idx_d;
      inh_q       <= inh_d;
      tmo_q       <= tmo_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // Next-state, shifter and status logic; clk_oe defaults to released.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    idx_d     = idx_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    ack_d     = ack_q;
    err_d     = err_q;
    clk_oe_d  = 1'b0;
    data_oe_d = ps2_data_oe;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    // A dropped write wins over a clearing STATUS read.
    if (write_hit && (state_q != IDLE)) ovr_d = 1'b1;
    else if (read_hit)                  ovr_d = 1'b0;
    else                                ovr_d = ovr_q;

    if (active) tmo_d = tmo_q + TMO_W'(1);

    if (timeout) begin
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RETRY_W'(MAX_RETRIES)) begin
        retry_d  = retry_q + RETRY_W'(1);
        inh_d    = '0;
        clk_oe_d = 1'b1;
        state_d  = INHIBIT;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
`else
      err_d   = 1'b1;
      state_d = IDLE;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          data_oe_d = 1'b0;
          if (write_hit) begin
            byte_d   = io_write_data[7:0];
            parity_d = odd_parity(io_write_data[7:0]);
            ack_d    = 1'b0;
            err_d    = 1'b0;
            inh_d    = '0;
            clk_oe_d = 1'b1;
            state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_d  = '0;
`endif
          end
        end
        INHIBIT: begin
          if (inh_q == INH_LAST) begin
            data_oe_d = 1'b1;
            idx_d     = '0;
            tmo_d     = '0;
            state_d   = REQUEST;
          end else begin
            inh_d     = inh_q + INH_W'(1);
            clk_oe_d  = 1'b1;
            data_oe_d = (inh_q == INH_PRELAST);
          end
        end
        REQUEST: begin
          if (fall) begin
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (fall) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q < IDX_W'(8)) begin
              data_oe_d = ~byte_q[idx_q[2:0]];
            end else if (idx_q == IDX_W'(8)) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end
          end
        end
        ACK: begin
          data_oe_d = 1'b0;
          if (fall) begin
            if (!data_sync) begin
              ack_d   = 1'b1;
              state_d = WAIT_IDLE;
            end else begin
`ifdef PS2_TX_RETRY_EN
              if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                retry_d  = retry_q + RETRY_W'(1);
                inh_d    = '0;
                clk_oe_d = 1'b1;
                state_d  = INHIBIT;
              end else begin
                err_d   = 1'b1;
                state_d = WAIT_IDLE;
              end
`else
              err_d   = 1'b1;
              state_d = WAIT_IDLE;
`endif
            end
          end
        end
        WAIT_IDLE: begin
          data_oe_d = 1'b0;
          if (clk_sync && data_sync) state_d = IDLE;
        end
        default: begin
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = (state_q != IDLE);
    status[STAT_ACK_OK]  = ack_q;
    status[STAT_ERROR]   = err_q;
    status[STAT_OVERRUN] = ovr_q;
`ifdef PS2_TX_RETRY_EN
    status[STAT_RETRY_LSB +: RETRY_W] = retry_q;
`endif
  end

  assign io_read_data = (io_address == STATUS_ADDR) ? status : '0;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Honours PS2_TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;

  localparam logic [31:0] BASE = 32'h60;
  localparam logic [31:0] STAT = 32'h64;
  localparam int unsigned INH  = 60;
  localparam int unsigned TMO  = 3000;
  localparam int          H    = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int          ATTEMPTS   = 3;
  localparam logic [31:0] ERR_STATUS = 32'h24;
`else
  localparam int          ATTEMPTS   = 1;
  localparam logic [31:0] ERR_STATUS = 32'h4;
`endif

  logic        clk, reset;
  logic        io_write_en, io_read_en;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic        ps2_clk_oe, ps2_data_oe;
  logic        dev_clk, dev_data;
  logic        ps2_clk_i, ps2_data_i;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  int n_cmp = 0;
  int n_err = 0;

  ps2_host_tx #(
    .BASE_ADDRESS  (BASE),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_write_en  (io_write_en),
    .io_read_en   (io_read_en),
    .io_address   (io_address),
    .io_write_data(io_write_data),
    .io_read_data (io_read_data),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(output logic [31:0] s);
    io_address = STAT;
    #1;
    s = io_read_data;
  endtask

  task automatic io_write(input logic [7:0] b);
    io_address    = BASE;
    io_write_data = {24'h0, b};
    io_write_en   = 1'b1;
    tick(1);
    io_write_en   = 1'b0;
    io_address    = STAT;
  endtask

  // Expected line levels sampled by the device: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((b >> i) & 8'd1) != 8'd0;
    f[9]  = ($countones(b) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic measure_inhibit(input bit chk_inh);
    int n, dhi;
    bit last;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin tick(1); n++; end
    check("inhibit_start", 32'(ps2_clk_oe), 32'd1);
    n = 0; dhi = 0; last = 1'b0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      dhi += ps2_data_oe ? 1 : 0;
      last = ps2_data_oe;
      tick(1);
    end
    if (chk_inh) begin
      check("inhibit_len", 32'(n), 32'(INH));
      check("start_bit_window", {dhi[30:0], last}, {31'd1, 1'b1});
    end
    check("request_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h1);
  endtask

  task automatic device_frame(input bit nack, input bit chk_inh, input int abort_k,
                              output logic [10:0] bits);
    bits = '0;
    measure_inhibit(chk_inh);
    tick(5);
    for (int k = 0; k < 12; k++) begin
      dev_clk = 1'b0;
      tick(H);
      dev_clk = 1'b1;
      if (k < 11) bits[k] = ps2_data_i;
      if (k == abort_k) return;
      tick(H);
      if (k == 10) dev_data = nack;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    rd(s);
    while (s[0] && n < int'(TMO) + 200) begin tick(1); rd(s); n++; end
    check(tag, 32'(s[0]), 32'd0);
  endtask

  task automatic send_ack(input logic [7:0] b, input string tag);
    logic [10:0] bits;
    logic [31:0] s;
    io_write(b);
    device_frame(1'b0, 1'b1, 99, bits);
    check({tag, "_bits"}, 32'(bits), 32'(frame_bits(b)));
    wait_idle({tag, "_idle"});
    rd(s);
    check({tag, "_status"}, s, 32'h2);
    check({tag, "_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h0);
  endtask

  initial begin : stim
    logic [10:0] bits;
    logic [31:0] s;
    int n;

    reset = 1'b1; io_write_en = 1'b0; io_read_en = 1'b0;
    io_address = STAT; io_write_data = '0;
    dev_clk = 1'b1; dev_data = 1'b1;
    tick(3);
    rd(s);
    check("reset_status", s, 32'h0);
    check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h0);
    reset = 1'b0;
    tick(5);

    // Directed and random ACKed frames.
    send_ack(8'hED, "ed");
    send_ack(8'h01, "x01");
    send_ack(8'h00, "x00");
    for (int i = 0; i < 4; i++) send_ack(8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));

    // NACK from the device on every attempt.
    io_write(8'h5A);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(1'b1, a == 0, 99, bits);
      check($sformatf("nack_bits%0d", a), 32'(bits), 32'(frame_bits(8'h5A)));
    end
    wait_idle("nack_idle");
    rd(s);
    check("nack_status", s, ERR_STATUS);

    // Device never clocks: each attempt lasts exactly TMO cycles after inhibit.
    io_write(8'hFF);
    for (int a = 0; a < ATTEMPTS; a++) begin
      measure_inhibit(1'b1);
      n = 0;
      rd(s);
      while (s[0] && !ps2_clk_oe && n < int'(TMO) + 50) begin tick(1); rd(s); n++; end
      check($sformatf("timeout_len%0d", a), 32'(n), 32'(TMO));
    end
    tick(INH + 10);
    rd(s);
    check("timeout_status", s, ERR_STATUS);
    check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h0);

    // Write while busy is dropped and flags overrun.
    io_write(8'hF3);
    io_write(8'h20);
    device_frame(1'b0, 1'b0, 99, bits);
    check("ovr_bits", 32'(bits), 32'(frame_bits(8'hF3)));
    wait_idle("ovr_idle");
    rd(s);
    check("ovr_status", s, 32'hA);
    io_address = BASE; io_read_en = 1'b1;
    tick(1);
    io_read_en = 1'b0;
    rd(s);
    check("ovr_data_read_keeps", s, 32'hA);
    io_read_en = 1'b1;
    tick(1);
    io_read_en = 1'b0;
    rd(s);
    check("ovr_cleared", s, 32'h2);
    io_write(8'h11);
    io_address = BASE; io_write_data = 32'h22; io_write_en = 1'b1; io_read_en = 1'b1;
    tick(1);
    io_write_en = 1'b0; io_read_en = 1'b0;
    rd(s);
    check("ovr_set_busy", s & 32'h9, 32'h9);
    device_frame(1'b0, 1'b0, 99, bits);
    check("ovr2_bits", 32'(bits), 32'(frame_bits(8'h11)));
    wait_idle("ovr2_idle");
    io_read_en = 1'b1;
    tick(1);
    io_read_en = 1'b0;
    rd(s);
    check("ovr2_cleared", s, 32'h2);

    // Reset while data bit 4 is on the line.
    io_write(8'hED);
    device_frame(1'b0, 1'b1, 5, bits);
    check("abort_partial", 32'(bits[5:0]), 32'(frame_bits(8'hED) & 11'h3F));
    reset = 1'b1;
    #1;
    check("abort_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h0);
    rd(s);
    check("abort_status", s, 32'h0);
    dev_clk = 1'b1; dev_data = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    send_ack(8'hED, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as set-LEDs 0xED, reset 0xFF and typematic 0xF3. It is the opposite direction of the existing ps2_controller receiver. It sits on the core IO bus next to ps2_controller and shares the ps2_clk/ps2_data open-drain lines through enables resolved in fpga_top: line = oe ? 1'b0 : 1'bz.

Parameters:
BASE_ADDRESS, 'h60, IO address of the DATA register; STATUS is at BASE_ADDRESS+4.
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ACK (15 ms).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
io_write_en  in  1  IO write strobe
io_read_en  in  1  IO read strobe
io_address  in  32  IO address
io_write_data  in  32  IO write data; [7:0] is the byte to send
io_read_data  out  32  STATUS value when io_address==BASE_ADDRESS+4, else 0; combinational, registered by the top-level mux
ps2_clk_i  in  1  raw ps2_clk pad input
ps2_data_i  in  1  raw ps2_data pad input
ps2_clk_oe  out  1  1 = drive ps2_clk low
ps2_data_oe  out  1  1 = drive ps2_data low

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, state IDLE, all status bits 0, counters 0.
- Input conditioning:
  - ps2_clk_i and ps2_data_i each pass through a 2-flop synchronizer.
  - fall = synced clock was 1 last cycle and is 0 this cycle.
- STATUS bits:
  - [0] busy = (state != IDLE).
  - [1] ack_ok.
  - [2] error (timeout or NACK).
  - [3] overrun, sticky.
  - [31:4] = 0.
- Write to BASE_ADDRESS in IDLE:
  - latch byte; parity = ~^byte (odd parity).
  - clear ack_ok and error; go to INHIBIT next cycle (busy visible the next cycle).
- Write to BASE_ADDRESS while busy: byte dropped, overrun set.
- Read of STATUS (io_read_en with matching address) clears overrun in the same cycle. If a dropped write occurs in that same cycle, set wins.
- INHIBIT:
  - ps2_clk_oe=1 for INHIBIT_CYCLES.
  - ps2_data_oe=1 during the last cycle (start bit = 0).
  - then go to REQUEST.
- REQUEST: ps2_clk_oe=0, ps2_data_oe=1; bit index=0; timeout counter starts.
- SEND, on each fall:
  - index 0-7: ps2_data_oe = ~byte[index] (LSB first).
  - index 8: ps2_data_oe = ~parity.
  - index 9: ps2_data_oe=0 (stop bit = 1).
  - then go to ACK.
  - REQUEST moves to SEND on its first fall.
- ACK, on the next fall:
  - synced data==0 gives ack_ok=1; data==1 gives error=1.
  - then go to WAIT_IDLE.
- WAIT_IDLE: return to IDLE once synced clock and data are both 1.
- Timeout: the counter runs from REQUEST through WAIT_IDLE. On reaching TIMEOUT_CYCLES: error=1, both oe=0, go to IDLE.
- Counter widths: $clog2 of the respective parameter plus 1; no wrap.
- Reset mid-frame: lines released immediately (asynchronous reset), status cleared.
- ps2_clk_oe is never asserted outside INHIBIT.

Optional Feature:
PS2_TX_RETRY_EN defined:
- On NACK or timeout, the frame is automatically reissued from INHIBIT up to 2 more times; a 2-bit retry counter resets on each new write.
- error is set only after the third failure; busy stays 1 across retries.
- STATUS[5:4] = retries used.
Undefined: the first failure sets error and returns to IDLE; STATUS[5:4] reads 0.

Decomposition:
- Package entries: state enum ps2_tx_state_t (IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE); localparams for the DATA/STATUS offsets and the STATUS bit positions.
- Existing synchronizer module is reused for both inputs. No new sub-module; the shifter and FSM stay inline.

Test Plan:
- Write 0xED; device model clocks at 12.5 kHz and ACKs -> sampled bits 0,1,0,1,1,0,1,1,1,p=1,stop=1; STATUS==0x2 after idle.
- Write 0x01 -> parity bit 0; write 0x00 -> parity bit 1; both ACK -> STATUS==0x2.
- Write 0xFF, device never clocks -> after TIMEOUT_CYCLES STATUS==0x4, both oe=0 (macro off); with the macro on, 3 inhibit pulses then STATUS==0x24.
- Device holds data high at the ACK clock (NACK) -> STATUS bit2=1, bit1=0.
- Write 0xF3 then 0x20 one cycle later -> only 0xF3 sent, STATUS bit3=1; a STATUS read clears it; a dropped write in the read cycle keeps it 1.
- Assert reset at data bit 4 -> ps2_clk_oe=ps2_data_oe=0 the same cycle, STATUS==0; a subsequent write of 0xED completes normally.
